// File: rtl/nibble_serial_tx_if.sv
// Nibble transmitter bus: valid/ready nibble handshake plus line status.
// slave = transmitter side, master = producer / observer side.
interface nibble_serial_tx_if;
  logic [3:0] din;
  logic       valid;
  logic       ready;
  logic       tx;
  logic       busy;
  logic       done;

  modport slave (
    input  din,
    input  valid,
    output ready,
    output tx,
    output busy,
    output done
  );

  modport master (
    output din,
    output valid,
    input  ready,
    input  tx,
    input  busy,
    input  done
  );
endinterface

// File: rtl/nibble_serial_tx.sv
// Nibble serial transmitter: start, 4 data LSB first, opt. even parity, stop.
// Ports: clk, rst (async high), bus (slave: din/valid in, ready/tx/busy/done out).
module nibble_serial_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter bit PARITY_EN    = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  nibble_serial_tx_if.slave   bus
);

  localparam int TW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic [1:0]    r_bitcnt;
  logic [3:0]    r_shift;
  logic          r_par;
  logic          r_tx;
  logic          r_done;

  logic          w_wrap;
  logic [TW-1:0] w_timer_nx;

  assign w_wrap     = (r_timer == LAST);
  assign w_timer_nx = w_wrap ? '0 : r_timer + 1'b1;

  assign bus.ready = (r_state == S_IDLE);
  assign bus.busy  = (r_state != S_IDLE);
  assign bus.tx    = r_tx;
  assign bus.done  = r_done;

  // tx is loaded one state ahead so each bit starts on its boundary edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_timer  <= '0;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_par    <= 1'b0;
      r_tx     <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          r_tx     <= 1'b1;
          r_timer  <= '0;
          r_bitcnt <= '0;
          if (bus.valid) begin
            r_shift <= bus.din;
            r_par   <= ^bus.din;
            r_tx    <= 1'b0;
            r_state <= S_START;
          end
        end
        S_START: begin
          r_timer <= w_timer_nx;
          if (w_wrap) begin
            r_tx    <= r_shift[0];
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          r_timer <= w_timer_nx;
          if (w_wrap) begin
            if (r_bitcnt == 2'd3) begin
              r_bitcnt <= '0;
              if (PARITY_EN) begin
                r_tx    <= r_par;
                r_state <= S_PARITY;
              end else begin
                r_tx    <= 1'b1;
                r_state <= S_STOP;
              end
            end else begin
              r_bitcnt <= r_bitcnt + 2'd1;
              r_shift  <= {1'b0, r_shift[3:1]};
              r_tx     <= r_shift[1];
            end
          end
        end
        S_PARITY: begin
          r_timer <= w_timer_nx;
          if (w_wrap) begin
            r_tx    <= 1'b1;
            r_state <= S_STOP;
          end
        end
        S_STOP: begin
          r_timer <= w_timer_nx;
          r_tx    <= 1'b1;
          if (w_wrap) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_tx.sv
// Self-checking bench for nibble_serial_tx: C=4/parity and C=1/no-parity.
// Reference frame computed from bit position arithmetic.
module tb_nibble_serial_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nibble_serial_tx_if ifa ();
  nibble_serial_tx_if ifb ();

  logic [3:0] din_a = '0;
  logic [3:0] din_b = '0;
  logic       valid_a = 1'b0;
  logic       valid_b = 1'b0;

  assign ifa.din   = din_a;
  assign ifa.valid = valid_a;
  assign ifb.din   = din_b;
  assign ifb.valid = valid_b;

  nibble_serial_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1)) u_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  nibble_serial_tx #(.CLKS_PER_BIT(1), .PARITY_EN(1'b0)) u_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  int total = 0;
  int bad   = 0;
  int na    = 0;
  int nb    = 0;

  always @(negedge clk) begin
    if (ifa.done === 1'b1) na++;
    if (ifb.done === 1'b1) nb++;
  end

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Line value during clock t after the accepting edge.
  function automatic logic exp_tx(input logic [3:0] d, input int t,
                                  input int c, input bit pen);
    int pos;
    pos = t / c;
    if (pos == 0) return 1'b0;
    if (pos <= 4) return d[pos-1];
    if (pen && pos == 5) return ^d;
    return 1'b1;
  endfunction

  task automatic set_din(input bit sel, input logic [3:0] v);
    if (sel) din_b = v;
    else din_a = v;
  endtask

  task automatic set_valid(input bit sel, input logic v);
    if (sel) valid_b = v;
    else valid_a = v;
  endtask

  task automatic chk_state(input bit sel, input string tag,
                           input logic etx, input logic ebusy,
                           input logic erdy, input logic edone);
    chk({tag, ".tx"},   sel ? ifb.tx   : ifa.tx,   etx);
    chk({tag, ".busy"}, sel ? ifb.busy : ifa.busy, ebusy);
    chk({tag, ".rdy"},  sel ? ifb.ready : ifa.ready, erdy);
    chk({tag, ".done"}, sel ? ifb.done : ifa.done, edone);
  endtask

  // Accepts d on the next edge and checks every clock through done.
  task automatic frame(input bit sel, input logic [3:0] d,
                       input int alt_t, input logic [3:0] alt,
                       input int vp_t, input int drop_t, input bit junk);
    int c;
    bit pen;
    int len;
    c   = sel ? 1 : 4;
    pen = !sel;
    len = c * (pen ? 7 : 6);
    set_din(sel, d);
    set_valid(sel, 1'b1);
    step();
    for (int t = 0; t <= len; t++) begin
      if (t == drop_t) set_valid(sel, 1'b0);
      if (t < len)
        chk_state(sel, $sformatf("f%0d_%h_t%0d", sel, d, t),
                  exp_tx(d, t, c, pen), 1'b1, 1'b0, 1'b0);
      else
        chk_state(sel, $sformatf("f%0d_%h_end", sel, d),
                  1'b1, 1'b0, 1'b1, 1'b1);
      if (t < len) begin
        if (junk) set_din(sel, 4'($urandom));
        if (t == alt_t) set_din(sel, alt);
        if (t == vp_t) set_valid(sel, 1'b1);
        else if (vp_t >= 0 && t == vp_t + 1) set_valid(sel, 1'b0);
        step();
      end
    end
  endtask

  initial begin
    int n0;
    logic [3:0] d;

    // Reset held with a pending request: nothing accepted.
    valid_a = 1'b1;
    din_a   = 4'h7;
    step();
    step();
    step();
    chk_state(0, "rst_a", 1'b1, 1'b0, 1'b1, 1'b0);
    chk_state(1, "rst_b", 1'b1, 1'b0, 1'b1, 1'b0);
    valid_a = 1'b0;
    rst     = 1'b0;
    step();
    chk_state(0, "post_rst", 1'b1, 1'b0, 1'b1, 1'b0);

    // Basic frame.
    frame(0, 4'b1011, -1, 4'h0, -1, 0, 1'b0);
    step();
    chk_state(0, "basic_idle", 1'b1, 1'b0, 1'b1, 1'b0);

    // Zero data, din moved to 1111 mid-frame.
    frame(0, 4'b0000, 6, 4'b1111, -1, 0, 1'b0);
    step();

    // Back-to-back with valid held.
    n0 = na;
    frame(0, 4'hA, 0, 4'h5, -1, -1, 1'b0);
    frame(0, 4'h5, -1, 4'h0, -1, 0, 1'b0);
    step();
    chk("b2b_dones", 8'(na - n0), 8'd2);
    chk_state(0, "b2b_idle", 1'b1, 1'b0, 1'b1, 1'b0);

    // Request during DATA is ignored.
    n0 = na;
    frame(0, 4'h9, -1, 4'h0, 10, 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk_state(0, $sformatf("ign_idle%0d", i), 1'b1, 1'b0, 1'b1, 1'b0);
    end
    chk("ign_dones", 8'(na - n0), 8'd1);

    // Reset during data bit 2.
    n0 = na;
    din_a   = 4'h6;
    valid_a = 1'b1;
    step();
    valid_a = 1'b0;
    for (int i = 0; i < 13; i++) step();
    chk("mid_pre_tx", ifa.tx, exp_tx(4'h6, 13, 4, 1'b1));
    rst = 1'b1;
    #1;
    chk_state(0, "mid_rst", 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 30; i++) step();
    chk("mid_no_done", 8'(na - n0), 8'd0);
    chk_state(0, "mid_idle", 1'b1, 1'b0, 1'b1, 1'b0);
    frame(0, 4'hC, -1, 4'h0, -1, 0, 1'b0);
    step();

    // Random frames, din scrambled during flight.
    n0 = na;
    for (int i = 0; i < 5; i++) begin
      d = 4'($urandom);
      frame(0, d, -1, 4'h0, -1, 0, 1'b1);
      for (int g = 0; g < int'($urandom_range(1, 3)); g++) step();
    end
    chk("rand_a_dones", 8'(na - n0), 8'd5);

    // C=1, no parity.
    n0 = nb;
    frame(1, 4'b0110, -1, 4'h0, -1, 0, 1'b0);
    step();
    for (int i = 0; i < 8; i++) begin
      d = 4'($urandom);
      frame(1, d, -1, 4'h0, -1, 0, 1'b1);
      if ($urandom_range(0, 1) == 1) step();
    end
    step();
    chk("b_dones", 8'(nb - n0), 8'd9);
    chk_state(1, "b_idle", 1'b1, 1'b0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
